// File: rtl/mem_wb_skid_stage.sv
// MEM->WB pipeline stage: valid/ready handshake, 2-entry skid buffer, synchronous flush.
// Optional performance counters are enabled by defining MEM_WB_PERF_CNT_EN.
module mem_wb_skid_stage #(
  parameter int PAYLOAD_W = 128,
  parameter int RD_W      = 5,
  parameter int ID_W      = 6,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [RD_W-1:0]      in_rd_addr,
  input  logic                 in_rd_valid,
  input  logic [ID_W-1:0]      in_instr_id,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [RD_W-1:0]      out_rd_addr,
  output logic                 out_rd_valid,
  output logic [ID_W-1:0]      out_instr_id,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     bubble_cycles
);

  logic                 main_valid;
  logic [PAYLOAD_W-1:0] main_payload;
  logic [RD_W-1:0]      main_rd_addr;
  logic                 main_rd_valid;
  logic [ID_W-1:0]      main_instr_id;

  logic                 skid_valid;
  logic [PAYLOAD_W-1:0] skid_payload;
  logic [RD_W-1:0]      skid_rd_addr;
  logic                 skid_rd_valid;
  logic [ID_W-1:0]      skid_instr_id;

  logic acc;
  logic main_advance;

  // in_ready comes only from the skid flop, so WB back-pressure never reaches MEM combinationally.
  assign in_ready     = ~skid_valid;
  assign acc          = in_valid & in_ready;
  assign main_advance = ~main_valid | out_ready;

  assign out_valid    = main_valid;
  assign out_payload  = main_payload;
  assign out_rd_addr  = main_rd_addr;
  assign out_rd_valid = main_rd_valid & main_valid;
  assign out_instr_id = main_instr_id;
  assign occupancy    = {1'b0, main_valid} + {1'b0, skid_valid};

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid    <= 1'b0;
      main_payload  <= '0;
      main_rd_addr  <= '0;
      main_rd_valid <= 1'b0;
      main_instr_id <= '0;
      skid_valid    <= 1'b0;
      skid_payload  <= '0;
      skid_rd_addr  <= '0;
      skid_rd_valid <= 1'b0;
      skid_instr_id <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_advance) begin
      // The skid entry is older than anything on the input, so it drains first.
      if (skid_valid) begin
        main_valid    <= 1'b1;
        main_payload  <= skid_payload;
        main_rd_addr  <= skid_rd_addr;
        main_rd_valid <= skid_rd_valid;
        main_instr_id <= skid_instr_id;
        skid_valid    <= 1'b0;
      end else if (acc) begin
        main_valid    <= 1'b1;
        main_payload  <= in_payload;
        main_rd_addr  <= in_rd_addr;
        main_rd_valid <= in_rd_valid;
        main_instr_id <= in_instr_id;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (acc) begin
      skid_valid    <= 1'b1;
      skid_payload  <= in_payload;
      skid_rd_addr  <= in_rd_addr;
      skid_rd_valid <= in_rd_valid;
      skid_instr_id <= in_instr_id;
    end
  end

`ifdef MEM_WB_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] bubble_q;

  // Counters look at pre-flush state and survive flush; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (main_valid && !out_ready && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_ONE;
      end
      if (!main_valid && out_ready && (bubble_q != '1)) begin
        bubble_q <= bubble_q + CNT_ONE;
      end
    end
  end

  assign stall_cycles  = stall_q;
  assign bubble_cycles = bubble_q;
`else
  assign stall_cycles  = '0;
  assign bubble_cycles = '0;
`endif

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Directed self-checking bench for mem_wb_skid_stage; a second instance with CNT_W=2 shares the stimulus.
module tb_mem_wb_skid_stage;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_payload;
  logic [4:0]   in_rd_addr;
  logic         in_rd_valid;
  logic [5:0]   in_instr_id;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_payload;
  logic [4:0]   out_rd_addr;
  logic         out_rd_valid;
  logic [5:0]   out_instr_id;
  logic [1:0]   occupancy;
  logic [31:0]  stall_cycles;
  logic [31:0]  bubble_cycles;

  logic         s_in_ready;
  logic         s_out_valid;
  logic [127:0] s_out_payload;
  logic [4:0]   s_out_rd_addr;
  logic         s_out_rd_valid;
  logic [5:0]   s_out_instr_id;
  logic [1:0]   s_occupancy;
  logic [1:0]   s_stall_cycles;
  logic [1:0]   s_bubble_cycles;

  int checks = 0;
  int errors = 0;

  mem_wb_skid_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
    .in_rd_addr(in_rd_addr), .in_rd_valid(in_rd_valid), .in_instr_id(in_instr_id),
    .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
    .out_rd_addr(out_rd_addr), .out_rd_valid(out_rd_valid), .out_instr_id(out_instr_id),
    .occupancy(occupancy), .stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles)
  );

  mem_wb_skid_stage #(.CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_payload(in_payload),
    .in_rd_addr(in_rd_addr), .in_rd_valid(in_rd_valid), .in_instr_id(in_instr_id),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_payload(s_out_payload),
    .out_rd_addr(s_out_rd_addr), .out_rd_valid(s_out_rd_valid), .out_instr_id(s_out_instr_id),
    .occupancy(s_occupancy), .stall_cycles(s_stall_cycles), .bubble_cycles(s_bubble_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [127:0] pl(input logic [5:0] id);
    return {4{26'h2ABCDE, id}};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic exp_valid, input logic [5:0] exp_id,
                             input logic exp_ready, input logic [1:0] exp_occ);
    chk({tag, ".out_valid"}, 128'(out_valid), 128'(exp_valid));
    chk({tag, ".out_instr_id"}, 128'(out_instr_id), 128'(exp_id));
    chk({tag, ".in_ready"}, 128'(in_ready), 128'(exp_ready));
    chk({tag, ".occupancy"}, 128'(occupancy), 128'(exp_occ));
  endtask

  // Drive one cycle of inputs, let the edge happen, then sample 1 time unit later.
  task automatic applyStimulus(input logic v, input logic [5:0] id, input logic rdv,
                               input logic [4:0] rda, input logic ordy, input logic fl,
                               input logic rs);
    in_valid    = v;
    in_instr_id = id;
    in_payload  = pl(id);
    in_rd_valid = rdv;
    in_rd_addr  = rda;
    out_ready   = ordy;
    flush       = fl;
    rst         = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_payload = '0;
    in_rd_addr = '0; in_rd_valid = 1'b0; in_instr_id = '0; out_ready = 1'b0;

    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("reset", 0, 0, 1, 0);
    chk("reset.payload", out_payload, 128'h0);
    chk("reset.rd_addr", 128'(out_rd_addr), 128'h0);
    chk("reset.rd_valid", 128'(out_rd_valid), 128'h0);

    // Streaming at full throughput
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1, 6'(k), 0, 0, 1, 0, 0);
      checkOutput($sformatf("stream%0d", k), 1, 6'(k), 1, 1);
      chk($sformatf("stream%0d.payload", k), out_payload, pl(6'(k)));
    end
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("stream_drain", 0, 8, 1, 0);

    // Back-pressure fills the skid entry
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    checkOutput("skid_a", 1, 1, 1, 1);
    applyStimulus(1, 2, 0, 0, 0, 0, 0);
    checkOutput("skid_b", 1, 1, 0, 2);
    applyStimulus(1, 2, 0, 0, 0, 0, 0);
    checkOutput("skid_c", 1, 1, 0, 2);
    applyStimulus(1, 2, 0, 0, 0, 0, 0);
    checkOutput("skid_d", 1, 1, 0, 2);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("skid_drain1", 1, 2, 1, 1);
    chk("skid_drain1.payload", out_payload, pl(2));
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("skid_drain2", 0, 2, 1, 0);

    // Flush while full, then flush with a live accept
    applyStimulus(1, 3, 0, 0, 0, 0, 0);
    checkOutput("flush_fill1", 1, 3, 1, 1);
    applyStimulus(1, 4, 0, 0, 0, 0, 0);
    checkOutput("flush_fill2", 1, 3, 0, 2);
    applyStimulus(1, 9, 0, 0, 0, 1, 0);
    checkOutput("flush_full", 0, 3, 1, 0);
    applyStimulus(1, 14, 0, 0, 0, 0, 0);
    checkOutput("flush_load", 1, 14, 1, 1);
    applyStimulus(1, 9, 0, 0, 0, 1, 0);
    checkOutput("flush_acc", 0, 14, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("flush_after", 0, 14, 1, 0);

    // rd_valid is masked on a bubble
    applyStimulus(1, 10, 1, 5, 1, 0, 0);
    checkOutput("rd_live", 1, 10, 1, 1);
    chk("rd_live.rd_valid", 128'(out_rd_valid), 128'h1);
    chk("rd_live.rd_addr", 128'(out_rd_addr), 128'h5);
    applyStimulus(0, 0, 1, 5, 1, 0, 0);
    checkOutput("rd_bubble", 0, 10, 1, 0);
    chk("rd_bubble.rd_valid", 128'(out_rd_valid), 128'h0);

    // Reset in the middle of a stall
    applyStimulus(1, 11, 1, 7, 0, 0, 0);
    checkOutput("rst_fill1", 1, 11, 1, 1);
    chk("rst_fill1.rd_valid", 128'(out_rd_valid), 128'h1);
    applyStimulus(1, 12, 0, 0, 0, 0, 0);
    checkOutput("rst_fill2", 1, 11, 0, 2);
    applyStimulus(1, 13, 0, 0, 0, 0, 1);
    checkOutput("rst_mid", 0, 0, 1, 0);
    chk("rst_mid.payload", out_payload, 128'h0);
    chk("rst_mid.rd_addr", 128'(out_rd_addr), 128'h0);
    chk("rst_mid.rd_valid", 128'(out_rd_valid), 128'h0);

    // One load, five stalled cycles, one take, two bubbles
    applyStimulus(1, 13, 0, 0, 0, 0, 0);
    checkOutput("cnt_load", 1, 13, 1, 1);
    for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("cnt_stalled", 1, 13, 1, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("cnt_empty", 0, 13, 1, 0);
`ifdef MEM_WB_PERF_CNT_EN
    chk("cnt.stall", 128'(stall_cycles), 128'd5);
    chk("cnt.bubble", 128'(bubble_cycles), 128'd2);
    chk("cnt.small_stall_sat", 128'(s_stall_cycles), 128'd3);
    chk("cnt.small_bubble", 128'(s_bubble_cycles), 128'd2);
`else
    chk("cnt.stall_off", 128'(stall_cycles), 128'd0);
    chk("cnt.bubble_off", 128'(bubble_cycles), 128'd0);
    chk("cnt.small_stall_off", 128'(s_stall_cycles), 128'd0);
`endif
    applyStimulus(0, 0, 0, 0, 1, 1, 0);
`ifdef MEM_WB_PERF_CNT_EN
    chk("cnt_flush.stall", 128'(stall_cycles), 128'd5);
    chk("cnt_flush.bubble", 128'(bubble_cycles), 128'd3);
    chk("cnt_flush.small_bubble_sat", 128'(s_bubble_cycles), 128'd3);
`else
    chk("cnt_flush.bubble_off", 128'(bubble_cycles), 128'd0);
`endif
    chk("small.occupancy", 128'(s_occupancy), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
